xhs_pipe: RTL and testbench

Parametrised valid/ready pipeline slice for the switch datapath. It replaces the single-register handshake stage with a chain of STAGES identical stages. Each stage runs in one of three modes: forward-registered, full skid (valid, data and ready all registered), or bypass. Adds a synchronous flush and an occupancy output, for timing closure on long routes between switch ports and arbiters.

---
 rtl/xhs_pkg.sv | 17 +
 rtl/xhs_stage.sv | 121 ++++++++++++
 rtl/xhs_pipe.sv | 69 ++++++
 tb/tb_xhs_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xhs_pkg.sv
// Shared types and helpers for the xhs valid/ready pipeline slice.
package xhs_pkg;

    typedef enum logic [1:0] {
        XHS_FWD  = 2'd0,
        XHS_SKID = 2'd1,
        XHS_BYP  = 2'd2
    } xhs_mode_e;

    localparam int XHS_MAX_STAGES = 8;

    // Occupancy width: enough bits to count two entries per stage.
    function automatic int xhs_occ_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/xhs_stage.sv
// One valid/ready stage: forward-registered, full skid, or bypass.
// o_cnt reports how many entries this stage currently holds.
module xhs_stage
    import xhs_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int MODE    = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_flush,
    input  logic               i_up_vld,
    output logic               o_up_rdy,
    input  logic [D_WIDTH-1:0] i_up_data,
    output logic               o_dn_vld,
    input  logic               i_dn_rdy,
    output logic [D_WIDTH-1:0] o_dn_data,
    output logic [1:0]         o_cnt
);

    localparam xhs_mode_e M = xhs_mode_e'(MODE);

    generate
        if (M == XHS_BYP) begin : g_byp
            assign o_dn_vld  = i_up_vld;
            assign o_up_rdy  = i_dn_rdy;
            assign o_dn_data = i_up_data;
            assign o_cnt     = 2'd0;
        end else if (M == XHS_FWD) begin : g_fwd
            logic               r_v;
            logic [D_WIDTH-1:0] r_d;
            logic               w_up_xfer;
            logic               w_dn_xfer;

            // Ready fills bubbles: accept when empty or draining this cycle.
            assign o_up_rdy  = i_dn_rdy | ~r_v;
            assign w_up_xfer = i_up_vld & o_up_rdy;
            assign w_dn_xfer = r_v & i_dn_rdy;

            // Single register pair; flush drops the entry but keeps the data.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_v <= 1'b0;
                    r_d <= '0;
                end else if (i_flush) begin
                    r_v <= 1'b0;
                end else if (w_up_xfer) begin
                    r_v <= 1'b1;
                    r_d <= i_up_data;
                end else if (w_dn_xfer) begin
                    r_v <= 1'b0;
                end
            end

            assign o_dn_vld  = r_v;
            assign o_dn_data = r_d;
            assign o_cnt     = {1'b0, r_v};
        end else begin : g_skid
            logic               r_mv, r_sv;
            logic [D_WIDTH-1:0] r_md, r_sd;
            logic               w_mv_n, w_sv_n;
            logic [D_WIDTH-1:0] w_md_n, w_sd_n;
            logic               w_up_xfer;
            logic               w_dn_xfer;

            // Ready depends only on the skid register, breaking the rdyo->rdyi path.
            assign o_up_rdy  = ~r_sv;
            assign w_up_xfer = i_up_vld & ~r_sv;
            assign w_dn_xfer = r_mv & i_dn_rdy;

            // Next main/skid contents; skid always refills main first to keep order.
            always_comb begin
                w_mv_n = r_mv;
                w_sv_n = r_sv;
                w_md_n = r_md;
                w_sd_n = r_sd;
                if (i_flush) begin
                    w_mv_n = 1'b0;
                    w_sv_n = 1'b0;
                end else if (w_dn_xfer) begin
                    if (r_sv) begin
                        w_md_n = r_sd;
                        w_sv_n = 1'b0;
                    end else if (w_up_xfer) begin
                        w_md_n = i_up_data;
                    end else begin
                        w_mv_n = 1'b0;
                    end
                end else if (w_up_xfer) begin
                    if (!r_mv) begin
                        w_mv_n = 1'b1;
                        w_md_n = i_up_data;
                    end else begin
                        w_sv_n = 1'b1;
                        w_sd_n = i_up_data;
                    end
                end
            end

            // Main and skid registers.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_mv <= 1'b0;
                    r_sv <= 1'b0;
                    r_md <= '0;
                    r_sd <= '0;
                end else begin
                    r_mv <= w_mv_n;
                    r_sv <= w_sv_n;
                    r_md <= w_md_n;
                    r_sd <= w_sd_n;
                end
            end

            assign o_dn_vld  = r_mv;
            assign o_dn_data = r_md;
            assign o_cnt     = {1'b0, r_mv} + {1'b0, r_sv};
        end
    endgenerate

endmodule

// File: rtl/xhs_pipe.sv
// Chain of STAGES identical handshake stages with flush and occupancy.
// Flush blanks both external handshakes so nothing transfers while entries drop.
module xhs_pipe
    import xhs_pkg::*;
#(
    parameter  int D_WIDTH = 16,
    parameter  int STAGES  = 2,
    parameter  int MODE    = 1,
    localparam int OCC_W   = xhs_occ_w(STAGES)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               vldi,
    output logic               rdyi,
    input  logic [D_WIDTH-1:0] datai,
    output logic               vldo,
    input  logic               rdyo,
    output logic [D_WIDTH-1:0] datao,
    output logic [OCC_W-1:0]   occ
);

    localparam xhs_mode_e M = xhs_mode_e'(MODE);

    logic               w_vld [STAGES+1];
    logic               w_rdy [STAGES+1];
    logic [D_WIDTH-1:0] w_dat [STAGES+1];
    logic [1:0]         w_cnt [STAGES];
    logic [OCC_W-1:0]   w_occ;
    logic               w_gate;

    assign w_vld[0]      = vldi;
    assign w_dat[0]      = datai;
    assign w_rdy[STAGES] = rdyo;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        xhs_stage #(
            .D_WIDTH(D_WIDTH),
            .MODE   (MODE)
        ) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .i_flush  (flush),
            .i_up_vld (w_vld[g]),
            .o_up_rdy (w_rdy[g]),
            .i_up_data(w_dat[g]),
            .o_dn_vld (w_vld[g+1]),
            .i_dn_rdy (w_rdy[g+1]),
            .o_dn_data(w_dat[g+1]),
            .o_cnt    (w_cnt[g])
        );
    end

    // Total entries held: sum of the per-stage counts, all register-derived.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_cnt[i]);
        end
    end

    // Bypass has no storage, so flush has nothing to act on there.
    assign w_gate = (M != XHS_BYP) && flush;
    assign rdyi   = w_rdy[0] & ~w_gate;
    assign vldo   = w_vld[STAGES] & ~w_gate;
    assign datao  = w_dat[STAGES];
    assign occ    = w_occ;

endmodule

// File: tb/tb_xhs_pipe.sv
// Bench for xhs_pipe: several configurations instantiated side by side,
// directed scenarios plus randomized traffic against a queue model.
module tb_xhs_pipe;

    localparam int NI = 10;
    localparam int CM [NI] = '{1, 1, 0, 0, 2, 0, 0, 1, 1, 1};
    localparam int CS [NI] = '{2, 3, 3, 4, 2, 1, 8, 1, 4, 8};

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        t_vldi  [NI];
    logic        t_flush [NI];
    logic        t_rdyo  [NI];
    logic        t_rdyi  [NI];
    logic        t_vldo  [NI];
    logic [15:0] t_datai [NI];
    logic [15:0] t_datao [NI];
    logic [4:0]  t_occ   [NI];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int OW = $clog2(2 * CS[g] + 1);
        logic [OW-1:0] w_occ;
        xhs_pipe #(
            .D_WIDTH(16),
            .STAGES (CS[g]),
            .MODE   (CM[g])
        ) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .flush(t_flush[g]),
            .vldi (t_vldi[g]),
            .rdyi (t_rdyi[g]),
            .datai(t_datai[g]),
            .vldo (t_vldo[g]),
            .rdyo (t_rdyo[g]),
            .datao(t_datao[g]),
            .occ  (w_occ)
        );
        assign t_occ[g] = 5'(w_occ);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NI; i++) begin
            t_vldi[i]  = 1'b0;
            t_flush[i] = 1'b0;
            t_rdyo[i]  = 1'b0;
            t_datai[i] = '0;
        end
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        int i = 0;
        do_reset();
        t_rdyo[i] = 1'b0;
        @(negedge clk);
        vec++;
        if (t_rdyi[i] !== 1'b1 || t_vldo[i] !== 1'b0 || t_occ[i] !== 5'd0 || t_datao[i] !== 16'h0) begin
            miss++;
            $display("FAIL reset_state: rdyi=%b vldo=%b occ=%0d datao=%h want 1 0 0 0000",
                     t_rdyi[i], t_vldo[i], t_occ[i], t_datao[i]);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            t_vldi[i]  = 1'b1;
            t_datai[i] = 16'hA0 + 16'(k);
            tick();
        end
        t_vldi[i] = 1'b0;
        @(negedge clk);
        vec++;
        if (t_occ[i] !== 5'd3 || t_vldo[i] !== 1'b1 || t_datao[i] !== 16'hA0) begin
            miss++;
            $display("FAIL reset_prefill: occ=%0d vldo=%b datao=%h want 3 1 00a0",
                     t_occ[i], t_vldo[i], t_datao[i]);
        end
        rstn = 1'b0;
        #1;
        vec++;
        if (t_vldo[i] !== 1'b0 || t_datao[i] !== 16'h0 || t_occ[i] !== 5'd0) begin
            miss++;
            $display("FAIL reset_async: vldo=%b datao=%h occ=%0d want 0 0000 0",
                     t_vldo[i], t_datao[i], t_occ[i]);
        end
        tick();
        rstn      = 1'b1;
        t_rdyo[i] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vec++;
            if (t_rdyi[i] !== 1'b1 || t_vldo[i] !== 1'b0 || t_occ[i] !== 5'd0) begin
                miss++;
                $display("FAIL reset_no_stale: cyc=%0d rdyi=%b vldo=%b occ=%0d want 1 0 0",
                         c, t_rdyi[i], t_vldo[i], t_occ[i]);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        int i   = 0;
        int lat = CS[0];
        logic exp_v;
        do_reset();
        t_rdyo[i] = 1'b1;
        for (int c = 0; c < 26; c++) begin
            t_vldi[i]  = (c < 16);
            t_datai[i] = 16'(c + 1);
            @(negedge clk);
            exp_v = (c >= lat) && (c < lat + 16);
            vec++;
            if (t_vldo[i] !== exp_v || (c < 16 && t_rdyi[i] !== 1'b1) ||
                (exp_v && t_datao[i] !== 16'(c - lat + 1))) begin
                miss++;
                $display("FAIL stream: cyc=%0d vldo=%b datao=%h rdyi=%b want vldo=%b datao=%h",
                         c, t_vldo[i], t_datao[i], t_rdyi[i], exp_v, 16'(c - lat + 1));
            end
            tick();
        end
    endtask

    task automatic test_backpressure(input int i);
        int cap = (CM[i] == 1) ? 2 * CS[i] : CS[i];
        int acc = 0;
        int got = 0;
        do_reset();
        t_rdyo[i] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            t_vldi[i]  = 1'b1;
            t_datai[i] = 16'(acc + 1);
            @(negedge clk);
            if (t_rdyi[i] === 1'b1) acc++;
            tick();
        end
        t_vldi[i] = 1'b0;
        @(negedge clk);
        vec++;
        if (acc != cap || t_rdyi[i] !== 1'b0 || int'(t_occ[i]) != cap) begin
            miss++;
            $display("FAIL bp_fill[%0d]: accepted=%0d rdyi=%b occ=%0d want %0d 0 %0d",
                     i, acc, t_rdyi[i], t_occ[i], cap, cap);
        end
        tick();
        t_rdyo[i] = 1'b1;
        for (int c = 0; c < 2 * cap + 10 && got < cap; c++) begin
            @(negedge clk);
            if (t_vldo[i] === 1'b1) begin
                vec++;
                if (t_datao[i] !== 16'(got + 1)) begin
                    miss++;
                    $display("FAIL bp_drain[%0d]: beat=%0d datao=%h want %h",
                             i, got, t_datao[i], 16'(got + 1));
                end
                got++;
            end
            tick();
        end
        @(negedge clk);
        vec++;
        if (got != cap || t_occ[i] !== 5'd0 || t_vldo[i] !== 1'b0) begin
            miss++;
            $display("FAIL bp_empty[%0d]: drained=%0d occ=%0d vldo=%b want %0d 0 0",
                     i, got, t_occ[i], t_vldo[i], cap);
        end
        tick();
    endtask

    task automatic test_flush();
        int i    = 3;
        int seen = 0;
        int bad  = 0;
        do_reset();
        t_rdyo[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t_vldi[i]  = 1'b1;
            t_datai[i] = 16'h100 + 16'(k);
            tick();
        end
        t_vldi[i] = 1'b0;
        @(negedge clk);
        vec++;
        if (t_occ[i] !== 5'd4 || t_rdyi[i] !== 1'b0 || t_vldo[i] !== 1'b1 || t_datao[i] !== 16'h100) begin
            miss++;
            $display("FAIL flush_fill: occ=%0d rdyi=%b vldo=%b datao=%h want 4 0 1 0100",
                     t_occ[i], t_rdyi[i], t_vldo[i], t_datao[i]);
        end
        tick();
        t_flush[i] = 1'b1;
        t_vldi[i]  = 1'b1;
        t_datai[i] = 16'hDEAD;
        t_rdyo[i]  = 1'b1;
        @(negedge clk);
        vec++;
        if (t_rdyi[i] !== 1'b0 || t_vldo[i] !== 1'b0) begin
            miss++;
            $display("FAIL flush_gate: rdyi=%b vldo=%b want 0 0", t_rdyi[i], t_vldo[i]);
        end
        tick();
        t_flush[i] = 1'b0;
        t_vldi[i]  = 1'b0;
        @(negedge clk);
        vec++;
        if (t_occ[i] !== 5'd0 || t_vldo[i] !== 1'b0) begin
            miss++;
            $display("FAIL flush_clear: occ=%0d vldo=%b want 0 0", t_occ[i], t_vldo[i]);
        end
        tick();
        t_vldi[i]  = 1'b1;
        t_datai[i] = 16'hBEEF;
        @(negedge clk);
        vec++;
        if (t_rdyi[i] !== 1'b1) begin
            miss++;
            $display("FAIL flush_reaccept: rdyi=%b want 1", t_rdyi[i]);
        end
        tick();
        t_vldi[i] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (t_vldo[i] === 1'b1) begin
                if (t_datao[i] === 16'hBEEF) seen++;
                else bad++;
            end
            tick();
        end
        vec++;
        if (seen != 1 || bad != 0) begin
            miss++;
            $display("FAIL flush_after: beef_seen=%0d other_beats=%0d want 1 0", seen, bad);
        end
    endtask

    task automatic test_bypass();
        int i = 4;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            t_vldi[i]  = 1'($urandom_range(0, 1));
            t_rdyo[i]  = 1'($urandom_range(0, 1));
            t_flush[i] = ($urandom_range(0, 9) == 0);
            t_datai[i] = 16'($urandom);
            @(negedge clk);
            vec++;
            if (t_vldo[i] !== t_vldi[i] || t_rdyi[i] !== t_rdyo[i] ||
                t_datao[i] !== t_datai[i] || t_occ[i] !== 5'd0) begin
                miss++;
                $display("FAIL bypass: cyc=%0d vldo=%b rdyi=%b datao=%h occ=%0d want %b %b %h 0",
                         c, t_vldo[i], t_rdyi[i], t_datao[i], t_occ[i],
                         t_vldi[i], t_rdyo[i], t_datai[i]);
            end
            tick();
        end
    endtask

    task automatic test_random(input int i, input int ncyc);
        logic [15:0] q[$];
        int   s     = CS[i];
        int   cap   = (CM[i] == 1) ? 2 * CS[i] : CS[i];
        int   total = ncyc + 4 * CS[i] + 10;
        logic pv = 1'b0, pr = 1'b0, pf = 1'b0;
        logic [15:0] pd = '0;
        logic drain;
        do_reset();
        for (int c = 0; c < total; c++) begin
            drain      = (c >= ncyc);
            t_vldi[i]  = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
            t_rdyo[i]  = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
            t_flush[i] = drain ? 1'b0 : ($urandom_range(0, 9) == 0);
            t_datai[i] = 16'($urandom);
            @(negedge clk);
            vec++;
            if (int'(t_occ[i]) != q.size()) begin
                miss++;
                $display("FAIL rnd_occ[m%0d s%0d]: cyc=%0d occ=%0d want %0d",
                         CM[i], s, c, t_occ[i], q.size());
            end
            vec++;
            if (t_vldo[i] !== 1'b0 && (q.size() == 0 || t_datao[i] !== q[0])) begin
                miss++;
                $display("FAIL rnd_data[m%0d s%0d]: cyc=%0d vldo=%b datao=%h want %h (queued %0d)",
                         CM[i], s, c, t_vldo[i], t_datao[i],
                         (q.size() > 0) ? q[0] : 16'h0, q.size());
            end
            if (pv && !pr && !pf && !t_flush[i]) begin
                vec++;
                if (t_vldo[i] !== 1'b1 || t_datao[i] !== pd) begin
                    miss++;
                    $display("FAIL rnd_hold[m%0d s%0d]: cyc=%0d vldo=%b datao=%h want 1 %h",
                             CM[i], s, c, t_vldo[i], t_datao[i], pd);
                end
            end
            if (q.size() == 0 && !t_flush[i]) begin
                vec++;
                if (t_rdyi[i] !== 1'b1) begin
                    miss++;
                    $display("FAIL rnd_empty_rdy[m%0d s%0d]: cyc=%0d rdyi=%b want 1",
                             CM[i], s, c, t_rdyi[i]);
                end
            end
            if (q.size() == cap && (CM[i] == 1 || !t_rdyo[i])) begin
                vec++;
                if (t_rdyi[i] !== 1'b0) begin
                    miss++;
                    $display("FAIL rnd_full_rdy[m%0d s%0d]: cyc=%0d rdyi=%b want 0",
                             CM[i], s, c, t_rdyi[i]);
                end
            end
            pv = t_vldo[i];
            pr = t_rdyo[i];
            pf = t_flush[i];
            pd = t_datao[i];
            if (t_flush[i]) begin
                q.delete();
            end else begin
                if (t_vldo[i] === 1'b1 && t_rdyo[i] && q.size() > 0) void'(q.pop_front());
                if (t_vldi[i] && t_rdyi[i] === 1'b1) q.push_back(t_datai[i]);
            end
            tick();
        end
        vec++;
        if (q.size() != 0) begin
            miss++;
            $display("FAIL rnd_drain[m%0d s%0d]: %0d beats never delivered, want 0",
                     CM[i], s, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure(1);
        test_backpressure(2);
        test_flush();
        test_bypass();
        test_random(3, 300);
        test_random(5, 300);
        test_random(6, 300);
        test_random(7, 300);
        test_random(8, 300);
        test_random(9, 300);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec, miss);
        $fatal(1, "time limit");
    end

endmodule
